// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: instruction field
// positions, opcode/aluop encodings and the sequencer state encoding.
package pipe_ctrl_pkg;

   localparam int unsigned IR_W  = 32;
   localparam int unsigned FLD_W = 5;

   // Instruction field bit ranges
   localparam int unsigned OP_HI  = 31;
   localparam int unsigned OP_LO  = 27;
   localparam int unsigned RD_HI  = 26;
   localparam int unsigned RD_LO  = 22;
   localparam int unsigned RS_HI  = 21;
   localparam int unsigned RS_LO  = 17;
   localparam int unsigned RT_HI  = 16;
   localparam int unsigned RT_LO  = 12;
   localparam int unsigned ALU_HI = 6;
   localparam int unsigned ALU_LO = 2;

   // Opcodes
   localparam logic [FLD_W-1:0] OP_RTYPE = 5'b00000;
   localparam logic [FLD_W-1:0] OP_LW    = 5'b01000;
   localparam logic [FLD_W-1:0] OP_SW    = 5'b00111;
   localparam logic [FLD_W-1:0] OP_BNE   = 5'b00010;
   localparam logic [FLD_W-1:0] OP_BLT   = 5'b00110;
   localparam logic [FLD_W-1:0] OP_JR    = 5'b00100;

   // R-type ALU operations that occupy the multdiv unit
   localparam logic [FLD_W-1:0] ALUOP_MUL = 5'b00110;
   localparam logic [FLD_W-1:0] ALUOP_DIV = 5'b00111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_MD_WAIT = 2'b01
   } state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational decode of the F/D and D/X instructions into hazard flags.
// Ports:
//   fd_ir     - instruction in the F/D latch
//   dx_ir     - instruction in the D/X latch
//   dx_md     - D/X holds a mul or div
//   dx_is_div - D/X mul/div is a div (aluop[0])
//   load_use  - D/X load writes a register that F/D reads
module pipe_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [IR_W-1:0] fd_ir,
   input  logic [IR_W-1:0] dx_ir,
   output logic            dx_md,
   output logic            dx_is_div,
   output logic            load_use
);

   logic [FLD_W-1:0] fd_op, fd_rd, fd_rs, fd_rt;
   logic [FLD_W-1:0] dx_op, dx_rd, dx_alu;
   logic             dx_lw, use_rd, use_rt;
   logic             unused_bits;

   assign fd_op  = fd_ir[OP_HI:OP_LO];
   assign fd_rd  = fd_ir[RD_HI:RD_LO];
   assign fd_rs  = fd_ir[RS_HI:RS_LO];
   assign fd_rt  = fd_ir[RT_HI:RT_LO];
   assign dx_op  = dx_ir[OP_HI:OP_LO];
   assign dx_rd  = dx_ir[RD_HI:RD_LO];
   assign dx_alu = dx_ir[ALU_HI:ALU_LO];

   // Fields not involved in hazard decisions
   assign unused_bits = ^{fd_ir[RT_LO-1:0], dx_ir[RS_HI:ALU_HI+1], dx_ir[ALU_LO-1:0]};

   // Which F/D source fields are real register reads
   always_comb begin
      use_rt = (fd_op == OP_RTYPE);
      use_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
               (fd_op == OP_BLT) || (fd_op == OP_JR);
   end

   always_comb begin
      dx_lw     = (dx_op == OP_LW);
      dx_md     = (dx_op == OP_RTYPE) && ((dx_alu == ALUOP_MUL) || (dx_alu == ALUOP_DIV));
      dx_is_div = dx_alu[0];
      // $0 is hardwired, so a load into it never creates a dependency
      load_use  = dx_lw && (dx_rd != '0) &&
                  ((dx_rd == fd_rs) ||
                   (use_rt && (dx_rd == fd_rt)) ||
                   (use_rd && (dx_rd == fd_rd)));
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline latch sequencer: PC/F/D/D/X enables, bubble selects and the
// multdiv handshake with a watchdog that forces release after MD_TIMEOUT.
// Ports:
//   clock, reset                 - clock, async active-high reset
//   in_fd_ir, in_dx_ir           - F/D and D/X instructions
//   in_branch_taken              - X-stage taken branch/jump
//   in_md_ready                  - multdiv result valid pulse
//   out_pc_en/fd_en/dx_en        - latch write enables
//   out_fd_nop/dx_nop/xm_nop     - bubble selects
//   out_md_start, out_md_is_div  - multdiv launch and op select
//   out_md_busy, out_md_timeout  - waiting on multdiv; sticky watchdog flag
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 40,
   parameter int unsigned CNT_W      = 6
)(
   input  logic            clock,
   input  logic            reset,
   input  logic [IR_W-1:0] in_fd_ir,
   input  logic [IR_W-1:0] in_dx_ir,
   input  logic            in_branch_taken,
   input  logic            in_md_ready,
   output logic            out_pc_en,
   output logic            out_fd_en,
   output logic            out_dx_en,
   output logic            out_fd_nop,
   output logic            out_dx_nop,
   output logic            out_xm_nop,
   output logic            out_md_start,
   output logic            out_md_is_div,
   output logic            out_md_busy,
   output logic            out_md_timeout
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout_flag, timeout_nxt;
   logic             dx_md, dx_is_div, load_use;

   pipe_hazard_detect u_hazard (
      .fd_ir     (in_fd_ir),
      .dx_ir     (in_dx_ir),
      .dx_md     (dx_md),
      .dx_is_div (dx_is_div),
      .load_use  (load_use)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         timeout_flag <= timeout_nxt;
      end
   end

   assign out_md_timeout = timeout_flag;

   // Next state and latch controls
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      timeout_nxt   = timeout_flag;
      out_pc_en     = 1'b1;
      out_fd_en     = 1'b1;
      out_dx_en     = 1'b1;
      out_fd_nop    = 1'b0;
      out_dx_nop    = 1'b0;
      out_xm_nop    = 1'b0;
      out_md_start  = 1'b0;
      out_md_is_div = 1'b0;
      out_md_busy   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (dx_md) begin
               out_md_start  = 1'b1;
               out_md_is_div = dx_is_div;
               out_pc_en     = 1'b0;
               out_fd_en     = 1'b0;
               out_dx_en     = 1'b0;
               out_xm_nop    = 1'b1;
               state_nxt     = ST_MD_WAIT;
               cnt_nxt       = '0;
            end else if (in_branch_taken) begin
               // Squash both younger instructions; supersedes any load-use stall
               out_fd_nop = 1'b1;
               out_dx_nop = 1'b1;
            end else if (load_use) begin
               out_pc_en  = 1'b0;
               out_fd_en  = 1'b0;
               out_dx_nop = 1'b1;
            end
         end

         ST_MD_WAIT: begin
            out_md_busy = 1'b1;
            if (in_md_ready) begin
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
               // Watchdog: let the pipe move but drop the missing result
               out_xm_nop  = 1'b1;
               timeout_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               out_pc_en  = 1'b0;
               out_fd_en  = 1'b0;
               out_dx_en  = 1'b0;
               out_xm_nop = 1'b1;
               cnt_nxt    = cnt + CNT_W'(1);
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
